out_alloc_rr: RTL
=================

// Module: out_alloc_rr
// PURPOSE
//  Per-output-port wormhole switch allocator for one router output.
//  - Selects one input port among the head flits routed to PORTID, using round-robin priority.
//  - Locks the output to the winning input until that packet's tail flit passes.
//  - Gates every forwarded flit on downstream credits.
//  - Drives the crossbar mux select and the input-buffer pop strobes; one instance per router output.
// PARAMETERS
//  PORTID  0  output port index this allocator serves
//  PORT_N  5  number of router input ports
//  PORT_W  3  width of per-input destination-port field
//  BUF_D   4  downstream buffer depth = initial/maximum credit count (>=1)
//  CNT_W   $clog2(BUF_D+1)  credit counter width (derived, do not override)
// PORTS
//  clk_i     in   1               clock, all state on rising edge
//  rst_ni    in   1               synchronous active-low reset
//  port_i    in   PORT_N*PORT_W   destination output port of each input's front flit
//  req_i     in   PORT_N          input i has a valid front flit
//  head_i    in   PORT_N          front flit of input i is a head flit
//  tail_i    in   PORT_N          front flit of input i is a tail flit (head+tail = single-flit packet)
//  credit_i  in   1               downstream freed one buffer slot this cycle
//  sel_o     out  PORT_N          one-hot crossbar select for this output (all-zero = none)
//  grt_o     out  PORT_N          one-hot pop strobe: input i's front flit is forwarded this cycle
//  vld_o     out  1               a flit leaves on this output this cycle (= |grt_o)
//  busy_o    out  1               output is locked to a packet (state LOCK)
//  cnt_o     out  CNT_W           current credit count (registered)
//  ovf_o     out  1               sticky: credit_i received while cnt == BUF_D
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge):
//  - state=IDLE, owner=0, rr_ptr=0, cnt=BUF_D, ovf=0.
//  - grt_o/sel_o/vld_o forced 0 while rst_ni=0.
//  - Reset mid-packet drops the lock; no flit is forwarded in the reset cycle.
//  Grant timing:
//  - grt_o, sel_o and vld_o are combinational from inputs and registered state (0-cycle latency).
//  - cnt_o, busy_o and ovf_o are registered.
//  - Credit gate uses the registered cnt only: cnt==0 blocks forwarding even if credit_i=1 that cycle.
//  IDLE:
//  - cand[i] = req_i[i] & head_i[i] & (port_i[i]==PORTID).
//  - If |cand and cnt>0: winner = first set cand index scanning rr_ptr, rr_ptr+1, ... mod PORT_N.
//    Then grt_o = sel_o = onehot(winner).
//  - Winner's tail_i=1: stay IDLE and set rr_ptr <= (winner+1) mod PORT_N.
//  - Winner's tail_i=0: go to LOCK, set owner <= winner, rr_ptr unchanged.
//  - No cand, or cnt==0: all outputs 0, no state change.
//  LOCK:
//  - sel_o = onehot(owner) every cycle, including stall cycles.
//  - grt_o = onehot(owner) iff req_i[owner] & cnt>0; otherwise 0 (bubble or backpressure).
//  - All other inputs are ignored, including head flits to PORTID.
//  - Owner's head_i is not checked; the flit is forwarded as body.
//  - Forwarded flit with tail_i[owner]=1: go to IDLE, set rr_ptr <= (owner+1) mod PORT_N.
//    The next grant is possible in the following cycle.
//  Credits: cnt_next = cnt - vld_o + credit_i.
//  - Forward and credit in the same cycle: cnt unchanged.
//  - credit_i with cnt==BUF_D and no forward: cnt stays BUF_D, ovf <= 1 (sticky until reset).
//  - cnt never underflows, because forwarding requires cnt>0.
//  Invariants:
//  - grt_o and sel_o are one-hot or zero.
//  - grt_o is a subset of sel_o.
//  - vld_o implies cnt>0.
// TESTING
//  - Reset: release rst_ni -> cnt_o=BUF_D (4), busy_o=0, grt_o=0; a 1-flit head+tail on input 2 to PORTID is granted in the same cycle.
//  - Round robin: inputs 0,1,3 each present single-flit packets every cycle with ample credits -> grants 0,1,3,0,1,3...
//  - Wormhole lock: input 1 sends a 4-flit packet while input 0 holds a head -> grt_o=0b00010 for 4 forwarding cycles, sel_o fixed; input 0 granted the cycle after the tail.
//  - Credit stall: BUF_D=4, no credit_i, 6-flit packet -> 4 flits forwarded, then grt_o=0 with sel_o held and busy_o=1; one credit_i pulse -> exactly 1 more flit, cnt_o back to 0.
//  - Simultaneous forward+credit at cnt=1 -> flit forwarded, cnt_o stays 1; credit_i at cnt=4 idle -> cnt_o=4, ovf_o=1 and stays 1.
//  - Reset mid-packet: assert rst_ni=0 during flit 2 of 4 -> next cycle busy_o=0, rr_ptr=0, cnt_o=4; a new head on input 3 is granted immediately.

Source files
------------

// File: rtl/out_alloc_rr.sv
// out_alloc_rr: wormhole switch allocator for one router output port.
// Round-robin arbitration among head flits destined to PORTID, holds the
// output for the winning packet until its tail, and gates every forwarded
// flit on the downstream credit count.
module out_alloc_rr #(
    parameter int PORTID = 0,
    parameter int PORT_N = 5,
    parameter int PORT_W = 3,
    parameter int BUF_D  = 4,
    parameter int CNT_W  = $clog2(BUF_D + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PORT_N*PORT_W-1:0] port_i,
    input  logic [PORT_N-1:0]        req_i,
    input  logic [PORT_N-1:0]        head_i,
    input  logic [PORT_N-1:0]        tail_i,
    input  logic                     credit_i,
    output logic [PORT_N-1:0]        sel_o,
    output logic [PORT_N-1:0]        grt_o,
    output logic                     vld_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         cnt_o,
    output logic                     ovf_o
);

    localparam int IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [PORT_N-1:0]  w_cand;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic               w_credit_ok;
    logic [PORT_N-1:0]  w_sel;
    logic [PORT_N-1:0]  w_grt;
    logic               w_vld;

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] p);
        return (32'(p) == 32'(PORT_N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_credit_ok = (r_cnt != '0);

    // Head flits of any input that are routed to this output.
    always_comb begin
        w_cand = '0;
        for (int unsigned i = 0; i < PORT_N; i++) begin
            w_cand[i] = req_i[i] & head_i[i]
                      & (port_i[i*PORT_W +: PORT_W] == PORT_W'(PORTID));
        end
    end

    // Round-robin pick: first candidate at or after r_rr_ptr, wrapping.
    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int unsigned k = 0; k < PORT_N; k++) begin
            v_idx = 32'(r_rr_ptr) + k;
            if (v_idx >= 32'(PORT_N)) begin
                v_idx = v_idx - 32'(PORT_N);
            end
            if (!w_found && w_cand[v_idx]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(v_idx);
            end
        end
    end

    // Crossbar select and pop strobes, zero-latency from inputs and state.
    always_comb begin
        w_sel = '0;
        w_grt = '0;
        if (rst_ni) begin
            if (r_state == ST_IDLE) begin
                if (w_found && w_credit_ok) begin
                    w_sel = PORT_N'(1) << w_win;
                    w_grt = PORT_N'(1) << w_win;
                end
            end else begin
                // Select stays on the owner through bubbles and stalls.
                w_sel = PORT_N'(1) << r_owner;
                if (req_i[r_owner] && w_credit_ok) begin
                    w_grt = PORT_N'(1) << r_owner;
                end
            end
        end
    end

    assign w_vld = |w_grt;

    // Lock/round-robin state and credit accounting.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= CNT_W'(BUF_D);
            r_ovf    <= 1'b0;
        end else begin
            if (w_vld) begin
                if (r_state == ST_IDLE) begin
                    if (tail_i[w_win]) begin
                        r_rr_ptr <= f_next(w_win);
                    end else begin
                        r_state <= ST_LOCK;
                        r_owner <= w_win;
                    end
                end else if (tail_i[r_owner]) begin
                    r_state  <= ST_IDLE;
                    r_rr_ptr <= f_next(r_owner);
                end
            end

            if (w_vld && !credit_i) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (!w_vld && credit_i) begin
                if (r_cnt == CNT_W'(BUF_D)) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign sel_o  = w_sel;
    assign grt_o  = w_grt;
    assign vld_o  = w_vld;
    assign busy_o = (r_state == ST_LOCK);
    assign cnt_o  = r_cnt;
    assign ovf_o  = r_ovf;

endmodule
